// File: rtl/cfi_ss_lifo.sv
// Return-address LIFO for the commit-stage CFI checker: registered top-of-stack, fill state,
// sticky overflow/underflow and high-water mark. Optional per-entry parity under CFI_SS_PARITY_EN.
module cfi_ss_lifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 100,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic [CNT_W-1:0]  o_hwm,
  output logic              o_overflow,
  output logic              o_underflow,
  input  logic              clr_err_i,
  output logic              o_parity_err
);

  localparam int AW = $clog2(DEPTH);
`ifdef CFI_SS_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  logic [MW-1:0]     r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count, r_hwm;
  logic [DATA_W-1:0] r_top;
  logic              r_ovf, r_udf;

  logic [CNT_W-1:0]  w_cnt_next, w_hwm_next, w_wr_cnt, w_rd_cnt;
  logic [DATA_W-1:0] w_top_next;
  logic              w_ovf_next, w_udf_next, w_we;
  logic [MW-1:0]     w_wr_word, w_rd_word;
  logic              w_full, w_empty;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_rd_cnt  = r_count - CNT_W'(2);
  assign w_rd_word = r_mem[w_rd_cnt[AW-1:0]];
`ifdef CFI_SS_PARITY_EN
  assign w_wr_word = {^i_data, i_data};
`else
  assign w_wr_word = i_data;
`endif

  always_comb begin
    w_cnt_next = r_count;
    w_top_next = r_top;
    w_ovf_next = r_ovf;
    w_udf_next = r_udf;
    w_we       = 1'b0;
    w_wr_cnt   = r_count;
    if (flush_i) begin
      w_cnt_next = '0;
      w_top_next = '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (w_full) begin
            w_ovf_next = 1'b1;
          end else begin
            w_we       = 1'b1;
            w_cnt_next = r_count + CNT_W'(1);
            w_top_next = i_data;
          end
        end
        2'b01: begin
          if (w_empty) begin
            w_udf_next = 1'b1;
          end else if (r_count == CNT_W'(1)) begin
            w_cnt_next = '0;
            w_top_next = '0;
          end else begin
            w_cnt_next = r_count - CNT_W'(1);
            w_top_next = w_rd_word[DATA_W-1:0];
          end
        end
        2'b11: begin
          // Simultaneous push/pop replaces the top; on an empty stack it degrades to a push.
          w_we       = 1'b1;
          w_top_next = i_data;
          if (w_empty) begin
            w_udf_next = 1'b1;
            w_cnt_next = CNT_W'(1);
          end else begin
            w_wr_cnt = r_count - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    w_hwm_next = (w_cnt_next > r_hwm) ? w_cnt_next : r_hwm;
    if (clr_err_i) begin
      w_ovf_next = 1'b0;
      w_udf_next = 1'b0;
      w_hwm_next = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && w_we) begin
      r_mem[w_wr_cnt[AW-1:0]] <= w_wr_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_count <= '0;
      r_top   <= '0;
      r_hwm   <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_cnt_next;
      r_top   <= w_top_next;
      r_hwm   <= w_hwm_next;
      r_ovf   <= w_ovf_next;
      r_udf   <= w_udf_next;
    end
  end

`ifdef CFI_SS_PARITY_EN
  logic r_top_par, r_perr, w_par_next;

  always_comb begin
    w_par_next = r_top_par;
    if (flush_i) begin
      w_par_next = 1'b0;
    end else if (i_push) begin
      w_par_next = (w_full && !i_pop) ? r_top_par : ^i_data;
    end else if (i_pop && !w_empty) begin
      w_par_next = (r_count == CNT_W'(1)) ? 1'b0 : w_rd_word[DATA_W];
    end
  end

  // Error is evaluated on the next-state top so it lines up with the o_data it describes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_top_par <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_top_par <= w_par_next;
      r_perr    <= (w_cnt_next != '0) && (w_par_next != ^w_top_next);
    end
  end

  assign o_parity_err = r_perr;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data      = r_top;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_count     = r_count;
  assign o_hwm       = r_hwm;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_udf;

endmodule

// File: tb/tb_cfi_ss_lifo.sv
// Directed bench for cfi_ss_lifo (DEPTH=4, 32-bit entries) with immediate-assertion checks.
module tb_cfi_ss_lifo;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0, push = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          full, empty, ovf, udf, perr;
  logic [CW-1:0] count, hwm;
  int            n_err = 0;
  int            n_chk = 0;

  always #5 clk = ~clk;

  cfi_ss_lifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .i_push(push), .i_data(din),
    .i_pop(pop), .o_data(dout), .o_full(full), .o_empty(empty), .o_count(count),
    .o_hwm(hwm), .o_overflow(ovf), .o_underflow(udf), .clr_err_i(clr),
    .o_parity_err(perr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic p, input logic [DW-1:0] d, input logic q,
                    input logic f, input logic c);
    push = p; din = d; pop = q; flush = f; clr = c;
    @(posedge clk);
    #1;
    push = 1'b0; din = '0; pop = 1'b0; flush = 1'b0; clr = 1'b0;
    $display("op push=%0b data=%h pop=%0b flush=%0b clr=%0b -> data=%h count=%0d hwm=%0d ovf=%0b udf=%0b perr=%0b",
             p, d, q, f, c, dout, count, hwm, ovf, udf, perr);
  endtask

`ifdef CFI_SS_PARITY_EN
  logic par_saved;
`endif

  initial begin
    // Reset, with a push in flight that must be discarded
    op(1, 32'hDEAD_BEEF, 0, 0, 0);
    op(0, 0, 0, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_data", dout, 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_hwm", 32'(hwm), 0);
    chk("rst_flags", {29'd0, ovf, udf, perr}, 0);
    rst_n = 1'b1;

    // Two pushes then a pop
    op(1, 32'h8000_0104, 0, 0, 0);
    op(1, 32'h8000_0208, 0, 0, 0);
    chk("p2_data", dout, 32'h8000_0208);
    chk("p2_count", 32'(count), 2);
    chk("p2_empty", 32'(empty), 0);
    op(0, 0, 1, 0, 0);
    chk("pop1_data", dout, 32'h8000_0104);
    chk("pop1_count", 32'(count), 1);
    op(0, 0, 1, 0, 0);
    chk("pop0_data", dout, 0);
    chk("pop0_empty", 32'(empty), 1);
    chk("pop0_udf", 32'(udf), 0);

    // Fill to DEPTH, overflow on the fifth push
    op(1, 32'h10, 0, 0, 0);
    op(1, 32'h20, 0, 0, 0);
    op(1, 32'h30, 0, 0, 0);
    chk("f3_full", 32'(full), 0);
    op(1, 32'h40, 0, 0, 0);
    chk("f4_full", 32'(full), 1);
    chk("f4_ovf", 32'(ovf), 0);
    op(1, 32'h50, 0, 0, 0);
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_data", dout, 32'h40);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_hwm", 32'(hwm), 4);

    // clr_err clears flags and hwm; replace-while-full does not overflow
    op(0, 0, 0, 0, 1);
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_hwm", 32'(hwm), 0);
    op(1, 32'h55, 1, 0, 0);
    chk("rep_full_data", dout, 32'h55);
    chk("rep_full_count", 32'(count), 4);
    chk("rep_full_ovf", 32'(ovf), 0);
    chk("rep_full_hwm", 32'(hwm), 4);
    op(0, 0, 1, 0, 0);
    chk("drain3", dout, 32'h30);
    op(0, 0, 1, 0, 0);
    chk("drain2", dout, 32'h20);
    op(0, 0, 1, 0, 0);
    chk("drain1", dout, 32'h10);
    op(0, 0, 1, 0, 0);
    chk("drain0_count", 32'(count), 0);

    // Underflow and its clear
    op(0, 0, 1, 0, 0);
    chk("udf_flag", 32'(udf), 1);
    chk("udf_count", 32'(count), 0);
    chk("udf_data", dout, 0);
    op(0, 0, 0, 0, 1);
    chk("udf_clr", 32'(udf), 0);

    // Push+pop replaces the top entry
    op(1, 32'hA0, 0, 0, 0);
    op(1, 32'hB0, 0, 0, 0);
    op(1, 32'hC0, 1, 0, 0);
    chk("rep_count", 32'(count), 2);
    chk("rep_data", dout, 32'hC0);
    op(0, 0, 1, 0, 0);
    chk("rep_pop", dout, 32'hA0);
    op(0, 0, 1, 0, 0);

    // Flush beats a same-cycle push and keeps hwm
    op(0, 0, 0, 0, 1);
    op(1, 32'h1, 0, 0, 0);
    op(1, 32'h2, 0, 0, 0);
    op(1, 32'h3, 0, 0, 0);
    op(1, 32'hFF, 0, 1, 0);
    chk("fl_count", 32'(count), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_data", dout, 0);
    chk("fl_hwm", 32'(hwm), 3);

    // Push+pop on empty: underflow flagged, push still performed
    op(1, 32'h77, 1, 0, 0);
    chk("pe_udf", 32'(udf), 1);
    chk("pe_count", 32'(count), 1);
    chk("pe_data", dout, 32'h77);
    op(0, 0, 1, 0, 1);
    chk("pe_clr", 32'(udf), 0);

    // Parity error on a corrupted top entry
    op(1, 32'h1234, 0, 0, 0);
    chk("par_clean", 32'(perr), 0);
`ifdef CFI_SS_PARITY_EN
    par_saved = dut.r_top_par;
    force dut.r_top_par = ~par_saved;
    op(0, 0, 0, 0, 0);
    chk("par_err", 32'(perr), 1);
    op(0, 0, 0, 0, 0);
    chk("par_hold", 32'(perr), 1);
    op(0, 0, 1, 0, 0);
    release dut.r_top_par;
`else
    op(0, 0, 0, 0, 0);
    chk("par_err", 32'(perr), 0);
    op(0, 0, 0, 0, 0);
    chk("par_hold", 32'(perr), 0);
    op(0, 0, 1, 0, 0);
`endif
    chk("par_pop", 32'(perr), 0);
    chk("par_pop_count", 32'(count), 0);

    // Reset mid-operation returns everything to reset values
    op(1, 32'h9, 0, 0, 0);
    op(1, 32'hA, 0, 0, 0);
    rst_n = 1'b0;
    op(1, 32'hB, 0, 0, 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_data", dout, 0);
    chk("mid_rst_hwm", 32'(hwm), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
